// File: rtl/load_store_unit.sv
// Load/store unit: sized, extended, strobed accesses over a handshaked data bus with timeout.
// Optional LSU_MISALIGN_SPLIT_EN: misaligned accesses are issued (split in two beats when crossing a word).
module load_store_unit #(
    parameter int XLEN           = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [4:0]        req_rd,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic [4:0]        resp_rd,
    output logic              resp_err,
    output logic              resp_misaligned,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN/8-1:0] mem_wstrb,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_err
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

`ifdef LSU_MISALIGN_SPLIT_EN
    typedef enum logic [1:0] {IDLE, BUS, BUS2} state_t;
`else
    typedef enum logic [1:0] {IDLE, BUS} state_t;
`endif

    // Byte-lane mask over two consecutive words; the upper half is the second beat of a split access.
    function automatic logic [2*NB-1:0] lane_mask(input logic [1:0] size, input logic [OFF_W-1:0] off);
        logic [2*NB-1:0] m;
        m = '0;
        for (int i = 0; i < NB; i++)
            if (i < (1 << size)) m[i] = 1'b1;
        return m << off;
    endfunction

    function automatic logic [XLEN-1:0] replicate(input logic [XLEN-1:0] wd, input logic [1:0] size,
                                                  input logic [OFF_W-1:0] off);
        logic [XLEN-1:0] r;
        int sel;
        r = '0;
        for (int i = 0; i < NB; i++) begin
            sel = (i - int'(off)) & ((1 << size) - 1) & (NB - 1);
            r[i*8 +: 8] = wd[sel*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [XLEN-1:0] load_extend(input logic [2*XLEN-1:0] b, input logic [OFF_W-1:0] off,
                                                    input logic [1:0] size, input logic uns);
        logic [2*XLEN-1:0] sh;
        logic [XLEN-1:0]   r;
        int nbits;
        sh    = b >> {off, 3'b000};
        nbits = 8 << size;
        if (nbits > XLEN) nbits = XLEN;
        r = '0;
        for (int i = 0; i < XLEN; i++)
            r[i] = (i < nbits) ? sh[i] : (sh[nbits-1] & ~uns);
        return r;
    endfunction

    state_t            state, state_d;
    logic [OFF_W-1:0]  req_off, off_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [4:0]        rd_q;
    logic [31:0]       cnt;
    logic              accept, size_ok, aligned, legal, tmo, last_beat;
    logic [NB-1:0]     strb_lo;
    logic [2*XLEN-1:0] rbuf;

    assign accept  = req_valid & req_ready;
    assign req_off = req_addr[OFF_W-1:0];
    assign size_ok = !(req_size == 2'd3 && XLEN == 32);
    assign aligned = ((int'(req_off) & ((1 << req_size) - 1)) == 0);
    assign strb_lo = NB'(lane_mask(req_size, req_off));
    assign tmo     = (TIMEOUT_CYCLES != 0) && (cnt == 32'(TIMEOUT_CYCLES - 1)) && !mem_ready;

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [NB-1:0]   strb_hi, strb_hi_q;
    logic [XLEN-1:0] lo_q;
    logic            cross_q, err_q;
    assign strb_hi   = NB'(lane_mask(req_size, req_off) >> NB);
    assign legal     = size_ok;
    assign last_beat = !(state == BUS && cross_q);
    assign rbuf      = (state == BUS2) ? {mem_rdata, lo_q} : {{XLEN{1'b0}}, mem_rdata};
`else
    assign legal     = size_ok && aligned;
    assign last_beat = 1'b1;
    assign rbuf      = {{XLEN{1'b0}}, mem_rdata};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (accept && legal) state_d = BUS;
`ifdef LSU_MISALIGN_SPLIT_EN
            BUS:  if (mem_ready) state_d = cross_q ? BUS2 : IDLE;
                  else if (tmo)  state_d = IDLE;
            BUS2: if (mem_ready || tmo) state_d = IDLE;
`else
            BUS:  if (mem_ready || tmo) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        mem_valid = (state != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_valid <= 1'b0; resp_rdata <= '0; resp_rd <= '0; resp_err <= 1'b0; resp_misaligned <= 1'b0;
            mem_write <= 1'b0; mem_addr <= '0; mem_wstrb <= '0; mem_wdata <= '0;
            off_q <= '0; size_q <= '0; uns_q <= 1'b0; rd_q <= '0; cnt <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            strb_hi_q <= '0; lo_q <= '0; cross_q <= 1'b0; err_q <= 1'b0;
`endif
        end else begin
            resp_valid <= 1'b0;
            if (accept) begin
                off_q <= req_off; size_q <= req_size; uns_q <= req_unsigned; rd_q <= req_rd; cnt <= '0;
                if (!legal) begin
                    resp_valid <= 1'b1; resp_misaligned <= 1'b1; resp_err <= 1'b0;
                    resp_rdata <= '0; resp_rd <= req_rd;
                end else begin
                    mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    mem_write <= req_write;
                    mem_wstrb <= strb_lo;
                    mem_wdata <= replicate(req_wdata, req_size, req_off);
`ifdef LSU_MISALIGN_SPLIT_EN
                    strb_hi_q <= strb_hi; cross_q <= |strb_hi; err_q <= 1'b0;
`endif
                end
            end else if (mem_valid) begin
                if (mem_ready && !last_beat) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                    // First beat of a split: keep its data/error, move on to the next word.
                    lo_q <= mem_rdata; err_q <= mem_err; cnt <= '0;
                    mem_addr <= mem_addr + ADDR_W'(NB); mem_wstrb <= strb_hi_q;
`endif
                end else if (mem_ready) begin
                    resp_valid <= 1'b1; resp_rd <= rd_q; resp_misaligned <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
                    resp_err   <= mem_err | err_q;
                    resp_rdata <= (mem_write || mem_err || err_q) ? '0 : load_extend(rbuf, off_q, size_q, uns_q);
`else
                    resp_err   <= mem_err;
                    resp_rdata <= (mem_write || mem_err) ? '0 : load_extend(rbuf, off_q, size_q, uns_q);
`endif
                end else if (tmo) begin
                    resp_valid <= 1'b1; resp_rd <= rd_q; resp_err <= 1'b1;
                    resp_misaligned <= 1'b0; resp_rdata <= '0;
                end else begin
                    cnt <= cnt + 32'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (XLEN=32, TIMEOUT_CYCLES=4); follows LSU_MISALIGN_SPLIT_EN if defined.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid, resp_err, resp_misaligned;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        mem_valid, mem_ready, mem_write, mem_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        seen;

    int n_checks = 0;
    int n_fail   = 0;

    load_store_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd), .resp_err(resp_err),
        .resp_misaligned(resp_misaligned),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the cycle after the accept edge.
    task automatic send(input logic wr, input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rd);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd; req_rd = rd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic bus_reply(input string tag, input int waits, input logic [31:0] rd, input logic err);
        for (int i = 0; i < waits; i++) begin
            check({tag, ".wait_valid"}, mem_valid, 1'b1);
            @(negedge clk);
        end
        mem_ready = 1'b1; mem_rdata = rd; mem_err = err;
        @(negedge clk);
        mem_ready = 1'b0; mem_rdata = '0; mem_err = 1'b0;
    endtask

    task automatic check_resp(input string tag, input logic [31:0] rdata, input logic [4:0] rd,
                              input logic err, input logic mis);
        check({tag, ".resp_valid"}, resp_valid, 1'b1);
        check({tag, ".resp_rdata"}, resp_rdata, rdata);
        check({tag, ".resp_rd"}, resp_rd, rd);
        check({tag, ".resp_err"}, resp_err, err);
        check({tag, ".resp_misaligned"}, resp_misaligned, mis);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".req_ready"}, req_ready, 1'b1);
        check({tag, ".resp_valid"}, resp_valid, 1'b0);
        check({tag, ".mem_valid"}, mem_valid, 1'b0);
        check({tag, ".mem_write"}, mem_write, 1'b0);
        check({tag, ".mem_addr"}, mem_addr, 32'h0);
        check({tag, ".mem_wstrb"}, mem_wstrb, 4'h0);
        check({tag, ".mem_wdata"}, mem_wdata, 32'h0);
        check({tag, ".resp_rdata"}, resp_rdata, 32'h0);
        check({tag, ".resp_rd"}, resp_rd, 5'd0);
        check({tag, ".resp_err"}, resp_err, 1'b0);
        check({tag, ".resp_misaligned"}, resp_misaligned, 1'b0);
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; req_rd = '0; mem_ready = 1'b0; mem_rdata = '0; mem_err = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b1;
        @(negedge clk);

        send(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 5'd5);
        check("lw.mem_valid", mem_valid, 1'b1);
        check("lw.mem_addr", mem_addr, 32'h8);
        check("lw.mem_wstrb", mem_wstrb, 4'b1111);
        check("lw.mem_write", mem_write, 1'b0);
        check("lw.req_ready", req_ready, 1'b0);
        bus_reply("lw", 0, 32'hDEADBEEF, 1'b0);
        check_resp("lw", 32'hDEADBEEF, 5'd5, 1'b0, 1'b0);
        check("lw.mem_valid_after", mem_valid, 1'b0);
        check("lw.req_ready_after", req_ready, 1'b1);
        @(negedge clk);
        check("lw.resp_pulse", resp_valid, 1'b0);

        send(1'b0, 2'd0, 1'b0, 32'h7, 32'h0, 5'd3);
        check("lb.mem_addr", mem_addr, 32'h4);
        check("lb.mem_wstrb", mem_wstrb, 4'b1000);
        bus_reply("lb", 0, 32'h80000000, 1'b0);
        check_resp("lb", 32'hFFFFFF80, 5'd3, 1'b0, 1'b0);

        send(1'b0, 2'd0, 1'b1, 32'h7, 32'h0, 5'd4);
        bus_reply("lbu", 0, 32'h80000000, 1'b0);
        check_resp("lbu", 32'h00000080, 5'd4, 1'b0, 1'b0);

        send(1'b0, 2'd1, 1'b0, 32'h2, 32'h0, 5'd6);
        check("lh.mem_wstrb", mem_wstrb, 4'b1100);
        bus_reply("lh", 2, 32'h80011234, 1'b0);
        check_resp("lh", 32'hFFFF8001, 5'd6, 1'b0, 1'b0);

        send(1'b1, 2'd1, 1'b0, 32'h2, 32'h1234ABCD, 5'd7);
        check("sh.mem_write", mem_write, 1'b1);
        check("sh.mem_addr", mem_addr, 32'h0);
        check("sh.mem_wstrb", mem_wstrb, 4'b1100);
        check("sh.mem_wdata", mem_wdata, 32'hABCDABCD);
        bus_reply("sh", 1, 32'h55555555, 1'b0);
        check_resp("sh", 32'h0, 5'd7, 1'b0, 1'b0);

        send(1'b1, 2'd0, 1'b0, 32'h1, 32'h000000EF, 5'd8);
        check("sb.mem_wstrb", mem_wstrb, 4'b0010);
        check("sb.mem_wdata", mem_wdata, 32'hEFEFEFEF);
        bus_reply("sb", 0, 32'h0, 1'b0);
        check_resp("sb", 32'h0, 5'd8, 1'b0, 1'b0);

        send(1'b0, 2'd2, 1'b0, 32'hC, 32'h0, 5'd10);
        bus_reply("err", 0, 32'h12345678, 1'b1);
        check_resp("err", 32'h0, 5'd10, 1'b1, 1'b0);

        send(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 5'd11);
        check("ld32.mem_valid", mem_valid, 1'b0);
        check_resp("ld32", 32'h0, 5'd11, 1'b0, 1'b1);
        check("ld32.req_ready", req_ready, 1'b1);

        send(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, 5'd12);
`ifdef LSU_MISALIGN_SPLIT_EN
        check("lw6.beat1_valid", mem_valid, 1'b1);
        check("lw6.beat1_addr", mem_addr, 32'h4);
        check("lw6.beat1_strb", mem_wstrb, 4'b1100);
        bus_reply("lw6.b1", 0, 32'hBBAA0000, 1'b0);
        check("lw6.beat2_valid", mem_valid, 1'b1);
        check("lw6.beat2_addr", mem_addr, 32'h8);
        check("lw6.beat2_strb", mem_wstrb, 4'b0011);
        check("lw6.no_early_resp", resp_valid, 1'b0);
        bus_reply("lw6.b2", 0, 32'h0000DDCC, 1'b0);
        check_resp("lw6", 32'hDDCCBBAA, 5'd12, 1'b0, 1'b0);
`else
        check("lw6.mem_valid", mem_valid, 1'b0);
        check_resp("lw6", 32'h0, 5'd12, 1'b0, 1'b1);
`endif

        send(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 5'd13);
        for (int i = 0; i < 4; i++) begin
            check("tmo.mem_valid_held", mem_valid, 1'b1);
            check("tmo.no_resp_yet", resp_valid, 1'b0);
            @(negedge clk);
        end
        check("tmo.mem_valid_dropped", mem_valid, 1'b0);
        check_resp("tmo", 32'h0, 5'd13, 1'b1, 1'b0);
        mem_ready = 1'b1; mem_rdata = 32'h11111111;
        @(negedge clk);
        mem_ready = 1'b0; mem_rdata = '0;
        check("tmo.late_ready_resp", resp_valid, 1'b0);
        check("tmo.late_ready_mem_valid", mem_valid, 1'b0);

        send(1'b1, 2'd2, 1'b0, 32'hC, 32'hCAFEF00D, 5'd14);
        check("rst.mem_valid_before", mem_valid, 1'b1);
        check("rst.mem_wdata_before", mem_wdata, 32'hCAFEF00D);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        @(negedge clk);
        reset = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            if (resp_valid || mem_valid) seen = 1'b1;
            @(negedge clk);
        end
        check("rst.no_resp_after_release", seen, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
